// File: rtl/ysyx_040066_icache_if.sv
// IFU fetch handshake plus AXI-bridge ins_* read channel of the icache.
// master = the cache; slave = its surroundings (IFU, bridge).
interface ysyx_040066_icache_if;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        flush;
  logic        ins_req;
  logic        ins_burst;
  logic [63:0] ins_addr;
  logic        ins_ready;
  logic        ins_last;
  logic        ins_err;
  logic [63:0] ins_data;

  modport master (
    input  fetch_req, fetch_addr, flush, ins_ready, ins_last, ins_err, ins_data,
    output fetch_done, fetch_rdata, fetch_err, ins_req, ins_burst, ins_addr
  );
  modport slave (
    output fetch_req, fetch_addr, flush, ins_ready, ins_last, ins_err, ins_data,
    input  fetch_done, fetch_rdata, fetch_err, ins_req, ins_burst, ins_addr
  );
endinterface

// File: rtl/ysyx_040066_icache.sv
// Direct-mapped 64x64B instruction cache; data in 4 external 128-bit SRAMs, tags/valid in flops.
// Optional flush support: define YSYX_040066_ICACHE_FLUSH_EN.
module ysyx_040066_icache (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_040066_icache_if.master  bus,
  output logic [5:0]            ram_A,
  output logic                  ram_WEN,
  output logic [127:0]          ram_BWEN,
  output logic [3:0][127:0]     ram_D,
  input  logic [3:0][127:0]     ram_Q
);
  localparam int SETS  = 64;
  localparam int TAG_W = 20;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, UNCACHED} state_t;

  state_t             state;
  logic [63:0]        addr_q;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tags [SETS];
  logic [511:0]       line_q;
  logic [2:0]         beat;
  logic               err_q;
  logic               flush_now;

  logic [5:0]         idx;
  logic [TAG_W-1:0]   tag_a;
  logic               misal, uncached, hit, last_beat;

  assign idx       = addr_q[11:6];
  assign tag_a     = addr_q[31:12];
  assign misal     = |addr_q[1:0];
  assign uncached  = ~addr_q[31];
  assign hit       = valid[idx] && (tags[idx] == tag_a);
  assign last_beat = bus.ins_ready && bus.ins_last;
  assign ram_D     = line_q;

`ifdef YSYX_040066_ICACHE_FLUSH_EN
  logic flush_pend;
  assign flush_now = (state == IDLE) && (bus.flush || flush_pend);

  // A flush seen mid-transaction waits for the next IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst)                 flush_pend <= 1'b0;
    else if (state == IDLE)  flush_pend <= 1'b0;
    else if (bus.flush)      flush_pend <= 1'b1;
  end
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_now    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid  <= '0;
      addr_q <= '0;
      beat   <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_now) valid <= '0;
          else if (bus.fetch_req) begin
            addr_q <= bus.fetch_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (misal)         state <= IDLE;
          else if (uncached) state <= UNCACHED;
          else if (hit)      state <= IDLE;
          else begin
            state <= REFILL;
            beat  <= '0;
            err_q <= 1'b0;
          end
        end
        REFILL: begin
          if (bus.ins_ready) begin
            // Index saturates at 7 so an over-long burst cannot wrap onto beat 0.
            line_q[{beat, 6'b0} +: 64] <= bus.ins_data;
            if (beat != 3'd7) beat <= beat + 3'd1;
            if (bus.ins_err)  err_q <= 1'b1;
            if (bus.ins_last) state <= (err_q || bus.ins_err) ? IDLE : WRITE;
          end
        end
        WRITE: begin
          valid[idx] <= 1'b1;
          tags[idx]  <= tag_a;
          state      <= IDLE;
        end
        UNCACHED: if (bus.ins_ready) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.fetch_done  = 1'b0;
    bus.fetch_err   = 1'b0;
    bus.fetch_rdata = '0;
    bus.ins_req     = 1'b0;
    bus.ins_burst   = 1'b0;
    bus.ins_addr    = '0;
    ram_A           = idx;
    ram_WEN         = 1'b1;
    ram_BWEN        = '1;
    case (state)
      IDLE: ram_A = bus.fetch_addr[11:6];
      LOOKUP: begin
        if (misal) begin
          bus.fetch_done = 1'b1;
          bus.fetch_err  = 1'b1;
        end else if (!uncached && hit) begin
          bus.fetch_done  = 1'b1;
          bus.fetch_rdata = ram_Q[addr_q[5:4]][{addr_q[3:2], 5'b0} +: 32];
        end
      end
      REFILL: begin
        bus.ins_req   = 1'b1;
        bus.ins_burst = 1'b1;
        bus.ins_addr  = {addr_q[63:6], 6'b0};
        if (last_beat && (err_q || bus.ins_err)) begin
          bus.fetch_done = 1'b1;
          bus.fetch_err  = 1'b1;
        end
      end
      WRITE: begin
        ram_WEN         = 1'b0;
        ram_BWEN        = '0;
        bus.fetch_done  = 1'b1;
        // SRAM still holds the old line this cycle; answer from the buffer.
        bus.fetch_rdata = line_q[{addr_q[5:2], 5'b0} +: 32];
      end
      UNCACHED: begin
        bus.ins_req  = 1'b1;
        bus.ins_addr = addr_q;
        if (bus.ins_ready) begin
          bus.fetch_done  = 1'b1;
          bus.fetch_err   = bus.ins_err;
          bus.fetch_rdata = addr_q[2] ? bus.ins_data[63:32] : bus.ins_data[31:0];
        end
      end
      default: ;
    endcase
    if (rst) bus.fetch_done = 1'b0;
  end
endmodule

// File: tb/tb_ysyx_040066_icache.sv
// Self-checking bench for ysyx_040066_icache: hashed memory + bridge/SRAM models, reference cache model.
module tb_ysyx_040066_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_040066_icache_if bus();
  logic [5:0]         ram_A;
  logic               ram_WEN;
  logic [127:0]       ram_BWEN;
  logic [3:0][127:0]  ram_D;
  logic [3:0][127:0]  ram_Q;

  ysyx_040066_icache dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_A(ram_A), .ram_WEN(ram_WEN), .ram_BWEN(ram_BWEN), .ram_D(ram_D), .ram_Q(ram_Q)
  );

  logic [3:0][127:0] sram [64];
  always @(posedge clk) begin
    if (!ram_WEN)
      for (int j = 0; j < 4; j++)
        sram[ram_A][j] <= (sram[ram_A][j] & ram_BWEN) | (ram_D[j] & ~ram_BWEN);
    ram_Q <= sram[ram_A];
  end

  int total = 0;
  int bad   = 0;
  int unsigned seed;
  bit          mv [64];
  logic [19:0] mt [64];
  int          err_beat   = -1;
  int          flush_beat = -1;
  bit          ovr_en     = 1'b0;
  logic [63:0] ovr_data   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] memf(input logic [63:0] a);
    logic [31:0] la;
    la = {a[31:3], 3'b000};
    return {la ^ 32'hDEAD_BEEF ^ seed, (la * 32'h9E37_79B1) ^ ~seed};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  // kind: 0 hit, 1 line burst, 2 single read, 3 misaligned
  task automatic do_fetch(input logic [63:0] a);
    int kind, idx, cyc, beat, writes;
    logic [19:0] tg;
    logic [63:0] bd, saw_addr;
    logic [31:0] exp_rd, rd;
    bit exp_err, burst_err, done, saw_req, saw_burst, er, flushed;
    idx = int'(a[11:6]);
    tg  = a[31:12];
    burst_err = 1'b0;
    exp_err   = 1'b0;
    if (a[1:0] != 2'b00) begin kind = 3; exp_err = 1'b1; end
    else if (!a[31]) begin kind = 2; exp_err = (err_beat == 0); end
    else if (mv[idx] && mt[idx] == tg) kind = 0;
    else begin kind = 1; burst_err = (err_beat >= 0); exp_err = burst_err; end
    bd     = ovr_en ? ovr_data : memf(a);
    exp_rd = a[2] ? bd[63:32] : bd[31:0];

    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    done = 0; cyc = 0; beat = 0; writes = 0; saw_req = 0; saw_burst = 0;
    saw_addr = '0; rd = '0; er = 0; flushed = 0;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      bus.ins_ready = 1'b0; bus.ins_last = 1'b0; bus.ins_err = 1'b0; bus.flush = 1'b0;
      if (bus.ins_req) begin
        if (!saw_req) begin saw_req = 1; saw_burst = bus.ins_burst; saw_addr = bus.ins_addr; end
        if ($urandom_range(0, 2) != 0) begin
          bus.ins_ready = 1'b1;
          if (bus.ins_burst) begin
            bus.ins_data = memf({a[63:6], 6'b0} + 64'(beat * 8));
            bus.ins_last = (beat == 7);
          end else begin
            bus.ins_data = ovr_en ? ovr_data : memf(a);
            bus.ins_last = 1'b1;
          end
          bus.ins_err = (beat == err_beat);
          if (beat == flush_beat && !flushed) begin bus.flush = 1'b1; flushed = 1; end
          beat++;
        end
      end
      #1;
      if (!ram_WEN) begin writes++; chk("write_idx", 64'(ram_A), 64'(idx)); end
      if (bus.fetch_done) begin done = 1; rd = bus.fetch_rdata; er = bus.fetch_err; end
    end
    chk("done", 64'(done), 64'd1);
    if (kind == 0 || kind == 3) chk("latency", 64'(cyc), 64'd1);
    chk("bus_req", 64'(saw_req), 64'(kind == 1 || kind == 2));
    if (kind == 1) begin
      chk("burst", 64'(saw_burst), 64'd1);
      chk("line_addr", saw_addr, {a[63:6], 6'b0});
      chk("beats", 64'(beat), 64'd8);
    end
    if (kind == 2) begin
      chk("burst", 64'(saw_burst), 64'd0);
      chk("single_addr", saw_addr, a);
    end
    chk("wen_cnt", 64'(writes), 64'(kind == 1 && !burst_err));
    chk("err", 64'(er), 64'(exp_err));
    if (!exp_err) chk("rdata", 64'(rd), 64'(exp_rd));

    @(negedge clk);
    bus.fetch_req = 1'b0; bus.ins_ready = 1'b0; bus.ins_last = 1'b0;
    bus.ins_err = 1'b0; bus.flush = 1'b0;
    #1;
    chk("req_after", 64'(bus.ins_req), 64'd0);
    chk("no_redone", 64'(bus.fetch_done), 64'd0);
    if (kind == 1 && !burst_err) begin mv[idx] = 1'b1; mt[idx] = tg; end
`ifdef YSYX_040066_ICACHE_FLUSH_EN
    if (flushed) model_clear();
`else
    if (flushed) chk("flush_knob_unused", 64'd1, 64'd0);
`endif
  endtask

  task automatic rst_mid(input logic [63:0] a);
    int n, cyc;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.ins_ready = bus.ins_req;
      bus.ins_last  = 1'b0;
      bus.ins_data  = memf({a[63:6], 6'b0} + 64'(n * 8));
      if (bus.ins_req) n++;
    end
    chk("rst_mid_beats", 64'(n), 64'd3);
    @(negedge clk);
    bus.ins_ready = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_done", 64'(bus.fetch_done), 64'd0);
    @(negedge clk);
    rst = 1'b0; bus.fetch_req = 1'b0;
    #1;
    chk("rst_mid_req", 64'(bus.ins_req), 64'd0);
    chk("rst_mid_done2", 64'(bus.fetch_done), 64'd0);
    model_clear();
  endtask

  initial begin
    logic [19:0] hi;
    logic [5:0]  ix, off;
    seed = $urandom;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.flush = 1'b0;
    bus.ins_ready = 1'b0; bus.ins_last = 1'b0; bus.ins_err = 1'b0; bus.ins_data = '0;
    model_clear();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", 64'(bus.fetch_done), 64'd0);
    chk("rst_err", 64'(bus.fetch_err), 64'd0);
    chk("rst_req", 64'(bus.ins_req), 64'd0);
    chk("rst_wen", 64'(ram_WEN), 64'd1);
    chk("rst_bwen", 64'(&ram_BWEN), 64'd1);
    rst = 1'b0;

    do_fetch(64'h8000_0044);           // cold miss, set 1
    do_fetch(64'h8000_0048);           // hit
    do_fetch(64'h8000_1044);           // conflict replaces tag
    do_fetch(64'h8000_0044);           // misses again
    ovr_en = 1'b1; ovr_data = 64'hAAAA_BBBB_CCCC_DDDD;
    do_fetch(64'h1000_0004);
    ovr_en = 1'b0;
    do_fetch(64'h8000_0046);           // misaligned
    err_beat = 3;
    do_fetch(64'h8000_0084);           // failed refill
    err_beat = -1;
    do_fetch(64'h8000_0084);           // must miss again
    do_fetch(64'h8000_0088);           // now a hit
    err_beat = 0;
    do_fetch(64'h2000_0000);           // uncached bus error
    err_beat = -1;
    rst_mid(64'h8000_0880);
    do_fetch(64'h8000_0048);           // reset invalidated everything

`ifdef YSYX_040066_ICACHE_FLUSH_EN
    flush_beat = 2;
    do_fetch(64'h8000_00C0);
    flush_beat = -1;
    do_fetch(64'h8000_00C4);           // flushed after write -> miss
    do_fetch(64'h8000_00C8);           // hit
    @(negedge clk);
    bus.flush = 1'b1; bus.fetch_req = 1'b1; bus.fetch_addr = 64'h8000_00C0;
    @(negedge clk);
    bus.flush = 1'b0; bus.fetch_req = 1'b0;
    #1;
    chk("flush_idle_done", 64'(bus.fetch_done), 64'd0);
    @(negedge clk);
    #1;
    chk("flush_idle_req", 64'(bus.ins_req), 64'd0);
    model_clear();
    do_fetch(64'h8000_00C0);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: hi = 20'h80000;
        1: hi = 20'h80001;
        2: hi = 20'h80042;
        default: hi = 20'h10000;
      endcase
      ix  = 6'($urandom_range(0, 3));
      off = 6'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 9) == 0) off[1] = 1'b1;
      err_beat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      do_fetch({32'h0, hi, ix, off});
    end
    err_beat = -1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
